// File: rtl/shift_midpoint_n_if.sv
// Board-side bundle for shift_midpoint_n: raw async inputs in, register view out.
interface shift_midpoint_n_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             button0;
    logic             switch0;
    logic             switch1;
    logic             dir;
    logic [WIDTH-1:0] parOut;
    logic             serialOut;
    logic [CW-1:0]    shiftCount;
    logic             full;

    modport master (
        output button0, switch0, switch1, dir,
        input  parOut, serialOut, shiftCount, full
    );

    modport slave (
        input  button0, switch0, switch1, dir,
        output parOut, serialOut, shiftCount, full
    );
endinterface

// File: rtl/shift_midpoint_n.sv
// Conditioned button/switch front end driving a parallel-load, bidirectional
// shift register with a saturating shift counter.
module shift_midpoint_n #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] LOAD_VALUE  = WIDTH'(8'hA5),
    parameter int               DEBOUNCE    = 10,
    parameter int               SYNC_STAGES = 2
) (
    input logic               Clk,
    input logic               Rst_n,
    shift_midpoint_n_if.slave bus
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int DCW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE - 1);

    // channel 0 = button0, 1 = switch0, 2 = switch1
    logic [2:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [DCW-1:0]         cnt_q  [3];
    logic [2:0]             cond_q;
    logic [2:0]             synced;
    logic [2:0]             fire;

    logic [SYNC_STAGES-1:0] dir_q;
    logic                   dir_s;

    logic [WIDTH-1:0]       par_q;
    logic [CW-1:0]          count_q;
    logic                   load;
    logic                   shift;

    assign raw   = {bus.switch1, bus.switch0, bus.button0};
    assign dir_s = dir_q[SYNC_STAGES-1];

    always_comb begin
        synced = '0;
        fire   = '0;
        for (int i = 0; i < 3; i++) begin
            synced[i] = sync_q[i][SYNC_STAGES-1];
            fire[i]   = (synced[i] != cond_q[i]) && (cnt_q[i] == DEB_LAST);
        end
    end

    // The edge pulses act on the register at the very edge they are produced.
    assign load  = fire[0] & cond_q[0];
    assign shift = fire[2] & ~cond_q[2];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            cond_q <= '0;
            dir_q  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                if (synced[i] == cond_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (fire[i]) begin
                    cnt_q[i]  <= '0;
                    cond_q[i] <= ~cond_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + DCW'(1);
                end
            end
            dir_q <= {dir_q[SYNC_STAGES-2:0], bus.dir};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            par_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            par_q   <= LOAD_VALUE;
            count_q <= '0;
        end else if (shift) begin
            if (dir_s) begin
                par_q <= {cond_q[1], par_q[WIDTH-1:1]};
            end else begin
                par_q <= {par_q[WIDTH-2:0], cond_q[1]};
            end
            if (count_q != CW'(WIDTH)) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign bus.parOut     = par_q;
    assign bus.serialOut  = dir_s ? par_q[0] : par_q[WIDTH-1];
    assign bus.shiftCount = count_q;
    assign bus.full       = (count_q == CW'(WIDTH));
endmodule

// File: tb/tb_shift_midpoint_n.sv
// Bench for shift_midpoint_n: directed scenarios plus random input activity,
// all checked against a sample-history reference model.
module tb_shift_midpoint_n;
    localparam int         W    = 8;
    localparam int         SYNC = 2;
    localparam int         DEB  = 4;
    localparam logic [7:0] LV   = 8'hA5;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    shift_midpoint_n_if #(.WIDTH(W)) bus ();

    shift_midpoint_n #(
        .WIDTH(W), .LOAD_VALUE(LV), .DEBOUNCE(DEB), .SYNC_STAGES(SYNC)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .bus(bus)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Model: raw sample history per input (bit 0 = newest), conditioned levels,
    // register contents and shift count.
    logic [15:0] hist [4];
    logic [2:0]  m_cond;
    logic [7:0]  m_par;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) hist[c] = '0;
        m_cond = '0;
        m_par  = '0;
        m_cnt  = 0;
    endtask

    // A conditioned level flips once the synchronised sample has disagreed
    // with it for DEB consecutive edges.
    task automatic model_edge();
        logic [3:0] raw;
        logic [2:0] fire;
        logic       d_s;
        logic       ld;
        logic       sh;
        if (!Rst_n) begin
            model_reset();
            return;
        end
        raw = {bus.dir, bus.switch1, bus.switch0, bus.button0};
        for (int c = 0; c < 4; c++) hist[c] = {hist[c][14:0], raw[c]};
        d_s  = hist[3][SYNC];
        fire = '1;
        for (int c = 0; c < 3; c++)
            for (int j = 0; j < DEB; j++)
                if (hist[c][SYNC+j] == m_cond[c]) fire[c] = 1'b0;
        ld = fire[0] && m_cond[0];
        sh = fire[2] && !m_cond[2];
        if (ld) begin
            m_par = LV;
            m_cnt = 0;
        end else if (sh) begin
            if (!d_s) m_par = 8'((int'(m_par) * 2 + int'(m_cond[1])) % 256);
            else      m_par = 8'(int'(m_par) / 2 + int'(m_cond[1]) * 128);
            if (m_cnt < W) m_cnt++;
        end
        m_cond = m_cond ^ fire;
    endtask

    task automatic compare_all(input string tag);
        logic dir_now;
        dir_now = hist[3][SYNC-1];
        chk({tag, ".par"},    32'(bus.parOut),     32'(m_par));
        chk({tag, ".cnt"},    32'(bus.shiftCount), 32'(m_cnt));
        chk({tag, ".full"},   32'(bus.full),       32'(m_cnt == W));
        chk({tag, ".serial"}, 32'(bus.serialOut),  32'(dir_now ? m_par[0] : m_par[7]));
    endtask

    task automatic step(input string tag);
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        compare_all(tag);
    endtask

    task automatic drive(input logic b0, input logic s0, input logic s1, input logic d,
                         input int n, input string tag);
        bus.button0 = b0;
        bus.switch0 = s0;
        bus.switch1 = s1;
        bus.dir     = d;
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic press(input logic s0, input logic d, input string tag);
        drive(1'b0, s0, 1'b1, d, 8, tag);
        drive(1'b0, s0, 1'b0, d, 8, tag);
    endtask

    task automatic load(input logic s0, input logic d, input string tag);
        drive(1'b1, s0, 1'b0, d, 10, tag);
        drive(1'b0, s0, 1'b0, d, 10, tag);
    endtask

    initial begin
        logic [7:0] exp4 [3];
        exp4[0] = 8'h4B;
        exp4[1] = 8'h97;
        exp4[2] = 8'h2F;
        model_reset();
        bus.button0 = 1'b0;
        bus.switch0 = 1'b0;
        bus.switch1 = 1'b0;
        bus.dir     = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3, "in_reset");
        chk("reset_par",  32'(bus.parOut),     32'h0);
        chk("reset_cnt",  32'(bus.shiftCount), 32'h0);
        chk("reset_full", 32'(bus.full),       32'h0);
        Rst_n = 1'b1;

        // load on release only, exactly SYNC+DEB edges after the fall
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12, "t2_rise");
        chk("t2_no_load_on_press", 32'(bus.parOut), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, SYNC + DEB - 1, "t2_fall");
        chk("t2_before_edge6", 32'(bus.parOut), 32'h0);
        step("t2_edge6");
        chk("t2_load_at_edge6", 32'(bus.parOut), 32'hA5);
        chk("t2_cnt", 32'(bus.shiftCount), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6, "t2_idle");

        // short switch1 glitch
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3, "t3_glitch");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10, "t3_idle");
        chk("t3_par", 32'(bus.parOut), 32'hA5);
        chk("t3_cnt", 32'(bus.shiftCount), 32'h0);

        // shift toward MSB with ones, then toward LSB with a zero
        drive(1'b0, 1'b1, 1'b0, 1'b0, 10, "t4_setup");
        for (int p = 0; p < 3; p++) begin
            press(1'b1, 1'b0, "t4_press");
            chk("t4_par", 32'(bus.parOut), 32'(exp4[p]));
        end
        chk("t4_cnt", 32'(bus.shiftCount), 32'd3);
        chk("t4_serial", 32'(bus.serialOut), 32'h0);
        load(1'b0, 1'b1, "t4_reload");
        chk("t4_reload_par", 32'(bus.parOut), 32'hA5);
        press(1'b0, 1'b1, "t4_lsb_press");
        chk("t4_lsb_par", 32'(bus.parOut), 32'h52);
        chk("t4_lsb_serial", 32'(bus.serialOut), 32'h0);

        // saturation and full
        load(1'b0, 1'b0, "t5_load");
        for (int p = 0; p < 9; p++) begin
            press(1'b0, 1'b0, "t5_press");
            if (p == 6) chk("t5_full_7", 32'(bus.full), 32'h0);
            if (p == 7) chk("t5_full_8", 32'(bus.full), 32'h1);
        end
        chk("t5_par", 32'(bus.parOut), 32'h0);
        chk("t5_cnt_sat", 32'(bus.shiftCount), 32'd8);
        chk("t5_full", 32'(bus.full), 32'h1);
        load(1'b0, 1'b0, "t5_reload");
        chk("t5_full_cleared", 32'(bus.full), 32'h0);

        // simultaneous load and shift pulses
        press(1'b0, 1'b0, "t6_pre");
        chk("t6_pre_par", 32'(bus.parOut), 32'h4A);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 10, "t6_arm");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10, "t6_both");
        chk("t6_par", 32'(bus.parOut), 32'hA5);
        chk("t6_cnt", 32'(bus.shiftCount), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10, "t6_after");
        chk("t6_no_deferred", 32'(bus.parOut), 32'hA5);

        // asynchronous reset with state present, button0 held high through it
        bus.button0 = 1'b1;
        #2;
        Rst_n = 1'b0;
        #1;
        chk("t1_par", 32'(bus.parOut), 32'h0);
        chk("t1_cnt", 32'(bus.shiftCount), 32'h0);
        chk("t1_full", 32'(bus.full), 32'h0);
        chk("t1_serial", 32'(bus.serialOut), 32'h0);
        model_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3, "t1_hold");
        Rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 10, "t1_high_after");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10, "t1_release");
        chk("t1_load_after_reset", 32'(bus.parOut), 32'hA5);

        // random activity: held levels of random length, including glitches
        for (int s = 0; s < 70; s++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(1, 14)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
